// File: rtl/lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// lfsr_period_monitor
//
// On-chip self-test checker placed directly after an `lfsr` block. On a `start`
// command it captures the seed the LFSR was loaded with. It waits for that seed
// to appear on the sample stream, then counts valid samples until the seed
// recurs. It reports the measured period, a maximal-length pass flag, and
// zero-lock, stuck-value and timeout errors.
//
// Configuration macro:
//   LFSR_MON_STUCK_CHECK_EN - when defined, two equal consecutive samples
//                             during COUNT end the measurement with stuck_err.
//                             When undefined, stuck_err is constant 0. A
//                             repeated value then counts as a normal sample,
//                             so a stuck LFSR ends through the timeout path.
//
// Parameters:
//   LENGTH       LFSR width in bits (must match the upstream lfsr)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle measurement command, accepted only in IDLE
//   seed         seed loaded into the upstream LFSR, captured on start
//   valid        data carries a new LFSR state this cycle
//   data         LFSR output
//   busy         measurement in progress; falls in the same cycle done is high
//   done         one-cycle pulse when a measurement ends
//   pass         last measured period equals 2^LENGTH-1
//   period       last measured period (LENGTH+1 bits), 0 on any error
//   zero_err     seed or a sample was all-zero
//   stuck_err    two consecutive samples were equal
//   timeout_err  the seed did not recur within 2^LENGTH samples
// -----------------------------------------------------------------------------
module lfsr_period_monitor #(
  parameter int LENGTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] seed,
  input  logic              valid,
  input  logic [LENGTH-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [LENGTH:0]   period,
  output logic              zero_err,
  output logic              stuck_err,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LENGTH:0] CNT_ONE  = {{LENGTH{1'b0}}, 1'b1};
  localparam logic [LENGTH:0] CNT_FULL = {1'b1, {LENGTH{1'b0}}};  // 2^LENGTH
  localparam logic [LENGTH:0] CNT_MAX  = CNT_FULL - CNT_ONE;      // 2^LENGTH-1

  state_t            state, state_d;
  logic [LENGTH-1:0] seed_q, seed_d;
  logic [LENGTH-1:0] prev_q, prev_d;
  logic [LENGTH:0]   cnt, cnt_d, cnt_inc;
  logic [LENGTH:0]   period_d;
  logic              pass_d, zero_d, stuck_d, timeout_d, busy_d;
  logic              stuck_hit;

  assign cnt_inc = cnt + CNT_ONE;

`ifdef LFSR_MON_STUCK_CHECK_EN
  assign stuck_hit = (data == prev_q);
`else
  // With the check removed, stuck_d is never set and the stuck_err register
  // stays at its reset value of 0.
  assign stuck_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default before the case, so
    // no path leaves a value unassigned and no latch is inferred.
    state_d   = state;
    seed_d    = seed_q;
    prev_d    = prev_q;
    cnt_d     = cnt;
    period_d  = period;
    pass_d    = pass;
    zero_d    = zero_err;
    stuck_d   = stuck_err;
    timeout_d = timeout_err;

    unique case (state)
      IDLE: begin
        if (start) begin
          seed_d    = seed;
          cnt_d     = '0;
          period_d  = '0;
          pass_d    = 1'b0;
          zero_d    = 1'b0;
          stuck_d   = 1'b0;
          timeout_d = 1'b0;
          if (seed == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ARM;
          end
        end
      end

      ARM: begin
        if (valid) begin
          if (data == seed_q) begin
            // The seed is the first sample of the period being measured.
            prev_d  = data;
            cnt_d   = CNT_ONE;
            state_d = COUNT;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              timeout_d = 1'b1;
              state_d   = DONE;
            end
          end
        end
      end

      COUNT: begin
        if (valid) begin
          if (data == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else if (stuck_hit) begin
            stuck_d = 1'b1;
            state_d = DONE;
          end else if (data == seed_q) begin
            period_d = cnt;
            pass_d   = (cnt == CNT_MAX);
            state_d  = DONE;
          end else begin
            cnt_d  = cnt_inc;
            prev_d = data;
            // Terminating here keeps cnt at 2^LENGTH at most, so it never wraps.
            if (cnt_inc == CNT_FULL) begin
              timeout_d = 1'b1;
              state_d   = DONE;
            end
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // busy covers ARM and COUNT and stays high through the DONE cycle, so it
    // drops on the same edge that raises done. The zero-seed path goes from
    // IDLE straight to DONE and never raises busy.
    busy_d = (state_d == ARM) || (state_d == COUNT) ||
             ((state_d == DONE) && (state != IDLE));
  end

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments, so every register
    // samples the values from before the edge regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      seed_q      <= '0;
      prev_q      <= '0;
      cnt         <= '0;
      period      <= '0;
      pass        <= 1'b0;
      zero_err    <= 1'b0;
      stuck_err   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      seed_q      <= seed_d;
      prev_q      <= prev_d;
      cnt         <= cnt_d;
      period      <= period_d;
      pass        <= pass_d;
      zero_err    <= zero_d;
      stuck_err   <= stuck_d;
      timeout_err <= timeout_d;
      busy        <= busy_d;
      done        <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_lfsr_period_monitor
//
// Self-checking bench for lfsr_period_monitor with LENGTH=4. Each scenario
// builds a sample stream and asks a reference model for the expected result.
// The model works on the list of valid samples: it finds the seed, measures the
// distance to its next occurrence, and applies the zero, stuck and timeout
// rules. It also names the valid sample that ends the measurement. The bench
// then checks that done rises on the second edge after that sample.
// -----------------------------------------------------------------------------
module tb_lfsr_period_monitor;

  localparam int L = 4;

`ifdef LFSR_MON_STUCK_CHECK_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, valid;
  logic [L-1:0] seed, data;
  logic         busy, done, pass, zero_err, stuck_err, timeout_err;
  logic [L:0]   period;

  always #5 clk = ~clk;

  lfsr_period_monitor #(.LENGTH(L)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .valid(valid),
    .data(data), .busy(busy), .done(done), .pass(pass), .period(period),
    .zero_err(zero_err), .stuck_err(stuck_err), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic       pass;
    logic [L:0] period;
    logic       zero_err;
    logic       stuck_err;
    logic       timeout_err;
  } res_t;

  typedef struct {
    res_t r;
    int   consumed;  // index (1-based) of the valid sample ending the run
  } exp_t;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] stim[$];

  // Fibonacci LFSR for x^4+x^3+1. From seed 6 the sequence runs 6,13,10,...
  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  task automatic fill_lfsr(input logic [3:0] first);
    logic [3:0] s = first;
    stim.delete();
    repeat (40) begin
      stim.push_back(s);
      s = lfsr_next(s);
    end
  endtask

  task automatic fill_cycle(input int p, input int off);
    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back(4'((off + i) % p));
  endtask

  // Reference model over the list of valid samples in stim.
  function automatic exp_t model(input logic [3:0] sd);
    exp_t e;
    int   a = -1;
    e.r = '0;
    e.consumed = 0;
    if (sd == 0) begin
      e.r.zero_err = 1'b1;
      return e;
    end
    for (int i = 0; i < 16; i++)
      if (stim[i] == sd) begin a = i; break; end
    if (a < 0) begin
      e.r.timeout_err = 1'b1;
      e.consumed = 16;
      return e;
    end
    for (int k = 1; k <= 15; k++) begin
      e.consumed = a + k + 1;
      if (stim[a+k] == 0) begin e.r.zero_err = 1'b1; return e; end
      if (STUCK_EN && stim[a+k] == stim[a+k-1]) begin e.r.stuck_err = 1'b1; return e; end
      if (stim[a+k] == sd) begin
        e.r.period = 5'(k);
        e.r.pass   = (k == 15);
        return e;
      end
    end
    e.r.timeout_err = 1'b1;  // 15 non-seed samples after the seed: count hits 16
    return e;
  endfunction

  // Drives one measurement. mode 0: valid always high. mode 1: valid toggles.
  // mode 2: random valid, plus stray start pulses while the monitor is busy.
  task automatic run(input logic [3:0] sd, input int mode, input int consumed,
                     output res_t got, output int done_e, output int exp_e,
                     output logic busy_pre, output logic busy_at,
                     output logic done_after);
    int   idx = 0, nv = 0, e = 0, samp_e = -10;
    logic pb = 1'b0, v;
    done_e = -1; got = '0; busy_pre = 1'b0; busy_at = 1'b0; done_after = 1'b0;
    @(negedge clk); start = 1'b1; seed = sd; valid = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (start) seed = 4'($urandom);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 1) == 1);
      if (v && idx < stim.size()) begin
        valid = 1'b1; data = stim[idx]; idx++;
      end else begin
        valid = 1'b0; data = 4'($urandom);
      end
      @(posedge clk); e++;
      if (valid) begin nv++; if (nv == consumed) samp_e = e; end
      #1;
      if (done) begin
        done_e = e; busy_pre = pb; busy_at = busy;
        got = {pass, period, zero_err, stuck_err, timeout_err};
        break;
      end
      pb = busy;
    end
    @(negedge clk); start = 1'b0; valid = 1'b0;
    @(posedge clk); #1 done_after = done;
    exp_e = (consumed == 0) ? 1 : samp_e + 1;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, pass, period, zero_err, stuck_err, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {busy, done, pass, period, zero_err, stuck_err, timeout_err});
    end
  endtask

  task automatic test_maximal();
    res_t got; int de, xe; logic bp, ba, da; exp_t ex;
    fill_lfsr(4'd6);
    ex = model(4'd6);
    run(4'd6, 0, ex.consumed, got, de, xe, bp, ba, da);
    checks++;
    if (got !== res_t'({1'b1, 5'd15, 3'b000})) begin
      failures++; $display("FAIL maximal_result got=%h exp=%h", got, res_t'({1'b1, 5'd15, 3'b000}));
    end
    checks++;
    if (de !== 17) begin failures++; $display("FAIL maximal_done_edge got=%0d exp=17", de); end
    checks++;
    if ({bp, ba, da} !== 3'b100) begin
      failures++; $display("FAIL maximal_busy_done got=%b exp=100", {bp, ba, da});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pass, period} !== {1'b1, 5'd15}) begin
      failures++; $display("FAIL result_hold got=%h exp=%h", {pass, period}, {1'b1, 5'd15});
    end
  endtask

  task automatic test_zero_seed();
    res_t got; int de, xe; logic bp, ba, da;
    fill_lfsr(4'd6);
    run(4'd0, 0, 0, got, de, xe, bp, ba, da);
    checks++;
    if (got !== res_t'({1'b0, 5'd0, 3'b100})) begin
      failures++; $display("FAIL zero_seed_result got=%h exp=%h", got, res_t'({1'b0, 5'd0, 3'b100}));
    end
    checks++;
    if (de !== 1 || da !== 1'b0) begin
      failures++; $display("FAIL zero_seed_done got=%0d/%b exp=1/0", de, da);
    end
  endtask

  task automatic test_stuck();
    res_t got, want; int de, xe; logic bp, ba, da; exp_t ex;
    stim.delete();
    stim.push_back(4'd6);
    repeat (39) stim.push_back(4'd13);
    ex = model(4'd6);
    want = STUCK_EN ? res_t'({1'b0, 5'd0, 3'b010}) : res_t'({1'b0, 5'd0, 3'b001});
    run(4'd6, 0, ex.consumed, got, de, xe, bp, ba, da);
    checks++;
    if (got !== want) begin failures++; $display("FAIL stuck_result got=%h exp=%h", got, want); end
    checks++;
    if (de !== (STUCK_EN ? 4 : 17)) begin
      failures++; $display("FAIL stuck_done_edge got=%0d exp=%0d", de, STUCK_EN ? 4 : 17);
    end
  endtask

  task automatic test_short_period();
    res_t got; int de, xe; logic bp, ba, da;
    fill_cycle(6, 0);
    for (int i = 0; i < 40; i++) if (stim[i] == 0) stim[i] = 4'd6;  // 6,1,2,3,4,5,...
    run(4'd6, 0, 7, got, de, xe, bp, ba, da);
    checks++;
    if (got !== res_t'({1'b0, 5'd6, 3'b000}) || de !== 8) begin
      failures++; $display("FAIL short_period got=%h@%0d exp=%h@8", got, de, res_t'({1'b0, 5'd6, 3'b000}));
    end
    run(4'd9, 0, 16, got, de, xe, bp, ba, da);
    checks++;
    if (got !== res_t'({1'b0, 5'd0, 3'b001}) || de !== 17) begin
      failures++; $display("FAIL arm_timeout got=%h@%0d exp=%h@17", got, de, res_t'({1'b0, 5'd0, 3'b001}));
    end
  endtask

  task automatic test_valid_toggle();
    res_t got; int de, xe; logic bp, ba, da; exp_t ex;
    fill_lfsr(4'd6);
    ex = model(4'd6);
    run(4'd6, 1, ex.consumed, got, de, xe, bp, ba, da);
    checks++;
    if (got !== res_t'({1'b1, 5'd15, 3'b000})) begin
      failures++; $display("FAIL toggle_result got=%h exp=%h", got, res_t'({1'b1, 5'd15, 3'b000}));
    end
    checks++;
    if (de !== xe) begin failures++; $display("FAIL toggle_done_edge got=%0d exp=%0d", de, xe); end
  endtask

  task automatic test_reset_mid();
    logic saw_done = 1'b0;
    fill_lfsr(4'd6);
    @(negedge clk); start = 1'b1; seed = 4'd6; valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = 1'b0; valid = 1'b1; data = stim[i];
      @(posedge clk);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, pass, period, zero_err, stuck_err, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b exp=0",
               {busy, done, pass, period, zero_err, stuck_err, timeout_err});
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 5; i < 10; i++) begin
      @(negedge clk); data = stim[i];
      @(posedge clk); #1 saw_done |= done;
    end
    @(negedge clk); valid = 1'b0;
    checks++;
    if (saw_done !== 1'b0) begin failures++; $display("FAIL reset_mid_no_done got=1 exp=0"); end
    test_maximal();
  endtask

  task automatic test_random();
    res_t got; int de, xe; logic bp, ba, da; exp_t ex; logic [3:0] sd;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        fill_lfsr(4'($urandom_range(1, 15)));
        sd = 4'($urandom_range(1, 15));
      end else begin
        stim.delete();
        repeat (40) stim.push_back(4'($urandom_range(0, 15)));
        sd = 4'($urandom_range(0, 15));
      end
      ex = model(sd);
      run(sd, $urandom_range(0, 2), ex.consumed, got, de, xe, bp, ba, da);
      checks++;
      if (got !== ex.r || de !== xe || ba !== 1'b0 || da !== 1'b0 || (sd != 0 && bp !== 1'b1)) begin
        failures++;
        $display("FAIL random_%0d seed=%0d got=%h@%0d busy=%b%b done_after=%b exp=%h@%0d",
                 it, sd, got, de, bp, ba, da, ex.r, xe);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; seed = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_maximal();
    test_zero_seed();
    test_stuck();
    test_short_period();
    test_valid_toggle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_period_monitor.md
# lfsr_period_monitor

Hardware checker that sits directly downstream of the `lfsr` block and consumes its `out` stream. On command it captures the seed, waits for the seed value to appear, then counts valid samples until the seed recurs. It reports the measured period, a pass flag for maximal length (2^LENGTH-1), and zero-lock, stuck-value and timeout errors. This moves the period, zero and repeat checks into synthesizable RTL for on-chip self-test.

## Interface
- `LENGTH`, default 4: LFSR width in bits; must match the upstream `lfsr`.
- `clk  input  1`: single clock, rising edge.
- `rst  input  1`: reset, synchronous, active-high.
- `start  input  1`: one-cycle command to begin a measurement; sampled only in IDLE.
- `seed  input  LENGTH`: seed the upstream LFSR was loaded with; captured when `start` is accepted.
- `valid  input  1`: `data` holds a new LFSR state this cycle.
- `data  input  LENGTH`: LFSR `out`.
- `busy  output  1`: measurement in progress (ARM or COUNT).
- `done  output  1`: one-cycle pulse when a measurement ends.
- `pass  output  1`: last measurement found period == 2^LENGTH-1.
- `period  output  LENGTH+1`: last measured period; 0 on any error.
- `zero_err  output  1`: the seed or a sample was all-zero.
- `stuck_err  output  1`: two consecutive valid samples were equal.
- `timeout_err  output  1`: more than 2^LENGTH valid samples arrived without the seed recurring.

## Operation
- States: IDLE, ARM, COUNT, DONE. Registers: `seed_q`, `prev_q`, and `cnt`, which is LENGTH+1 bits wide.
- IDLE: on `start`, capture `seed_q`, clear all result outputs and set `cnt=0`.
  - If `seed==0`: set `zero_err`, go to DONE.
  - Otherwise go to ARM.
- ARM: each valid sample increments `cnt`.
  - On `data==seed_q`: set `prev_q=data` and `cnt=1`, go to COUNT.
  - If `cnt` reaches 2^LENGTH first: set `timeout_err`, go to DONE.
- COUNT: each valid sample is checked in this priority order:
  1. `data==0`: set `zero_err`, go to DONE.
  2. `data==prev_q`: set `stuck_err`, go to DONE. Gated by configuration.
  3. `data==seed_q`: set `period=cnt` and `pass=(cnt==2^LENGTH-1)`, go to DONE.
  4. Otherwise increment `cnt` and set `prev_q=data`. If the incremented `cnt` equals 2^LENGTH, set `timeout_err` and go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE unconditionally.
- Any error forces `period=0` and `pass=0`. At most one error flag is set per measurement.
- `valid` low: no state or counter change in any state.
- `start` outside IDLE is ignored, including in the DONE cycle.
- Result outputs hold until the next accepted `start` or `rst`.
- Period arithmetic is unsigned, and `cnt` saturates at 2^LENGTH with no wrap.

## Timing
- Reset (`rst` high at a rising edge):
  - State returns to IDLE.
  - `busy`, `done`, `pass`, `zero_err`, `stuck_err` and `timeout_err` go to 0.
  - `period`, `cnt`, `seed_q` and `prev_q` go to 0.
  - Reset mid-measurement aborts it with no `done` pulse. `rst` has priority over `start`.
- All outputs are registered.
- `busy` rises in the cycle after `start` is accepted, and falls in the same cycle that `done` is high.
- Result flags and `period` update on the edge that samples the terminating `data`. `done` is high during the following cycle.
- Zero-seed path: `start` at edge N gives `zero_err` after edge N and `done` high in the cycle after edge N+1.
- Latency from the seed re-appearing to `done` is 2 cycles.
- Throughput: one sample per cycle. `valid` may be tied high.

## Configuration
- `LFSR_MON_STUCK_CHECK_EN` defined: the stuck check is active and `stuck_err` behaves as specified.
- Macro undefined:
  - The `prev_q` comparison is removed and `stuck_err` is tied 0.
  - A repeated value is counted as a normal sample, so a stuck LFSR ends through the timeout path.

## Test plan
- LENGTH=4, upstream taps x^4+x^3+1, seed=6, `valid` high: `done` after 15 samples past arm, with `period=15`, `pass=1` and no errors.
- Seed=0: `zero_err=1`, `period=0`, `pass=0`, and `done` two cycles after `start`.
- Stream 6,13,13 (macro defined): `stuck_err=1` on the second 13. Macro undefined: the same stuck stream gives `timeout_err=1` once `cnt` reaches 16.
- Seed=6 with a period-6 stream cycling 6,1,2,3,4,5: `period=6`, `pass=0`, no errors. The same stream with seed=9 (never present): `timeout_err=1` after 16 valid samples in ARM.
- `valid` toggling every other cycle on the maximal stream: `period=15`, and `done` latency is measured in valid samples, not cycles.
- `rst` pulsed while in COUNT: outputs go to 0 next cycle with no `done` pulse. A following `start` with seed=6 measures `period=15` correctly.
